execute_stage_mc: RTL and testbench
===================================

// Module: execute_stage_mc
// PURPOSE
//  Parametrised RV32/RV64 execute stage with registered EX/MEM boundary. Selects forwarded operands, runs the ALU, and resolves branches/jumps.
//  Adds an iterative shift-add multiplier (MUL, MULHU) that stalls decode via ready_E.
//  Sits between the ID/EX register and the memory stage.
// PARAMETERS
//  XLEN        32  datapath width (32 or 64)
//  MUL_ENABLE  1   0: MUL/MULHU decode as ADD, multiplier not built
//  REG_AW      5   register-address width
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        synchronous reset, active-low
//  valid_E       in   1        instruction present in EX
//  ready_E       out  1        EX can accept; 0 while multiplier busy/holding
//  flush_E       in   1        kill EX instruction (taken branch / hazard unit)
//  stall_M       in   1        hold EX/MEM register
//  RD1_E,RD2_E   in   XLEN     register-file operands
//  ImmExt_E      in   XLEN     sign-extended immediate
//  PC_E          in   XLEN     instruction PC
//  PCPlus4_E     in   XLEN     PC+4
//  Rd_E          in   REG_AW   destination register
//  ALUControl_E  in   4        op code, see package
//  ALUSrc_E      in   1        1: B operand = ImmExt_E
//  BranchOp_E    in   3        BEQ/BNE/BLT/BGE/BLTU/BGEU
//  Branch_E      in   1        conditional branch
//  Jump_E        in   1        unconditional jump
//  RegWrite_E, MemWrite_E   in  1     control passed down
//  ResultSrc_E   in   2        control passed down
//  ForwardA_E,ForwardB_E    in  2     00 RF, 01 ResultW, 10 AluResult_M
//  ResultW       in   XLEN     write-back value
//  PCSrc_E       out  1        redirect fetch (combinational)
//  PCTarget_E    out  XLEN     PC_E + ImmExt_E (combinational)
//  valid_M, RegWrite_M, MemWrite_M  out  1    registered
//  ResultSrc_M   out  2        registered
//  Rd_M          out  REG_AW   registered
//  AluResult_M, WriteData_M, PCPlus4_M  out  XLEN  registered
// BEHAVIOUR
//  - Reset (rst=0 at posedge): all *_M outputs 0, FSM IDLE, counter 0, ready_E=1.
//  - Operands: SrcA = fwd(ForwardA_E); WriteData = fwd(ForwardB_E); SrcB = ALUSrc_E ? ImmExt_E : WriteData. Encoding 11 behaves as 00.
//  - ALU ops are single-cycle: ADD SUB AND OR XOR SLT SLTU SLL SRL SRA. Shift amount is SrcB[$clog2(XLEN)-1:0]. All results wrap modulo 2^XLEN.
//  - Branch: PCSrc_E = valid_E & ~flush_E & FSM==IDLE & (Jump_E | Branch_E & cond(BranchOp_E,SrcA,SrcB)). Signed compares for BLT/BGE.
//  - FSM IDLE:
//    - valid_E & ~flush_E & MUL-op: latch SrcA, SrcB and control; clear accumulator; go BUSY; bubble into EX/MEM if ~stall_M.
//    - Otherwise, if ~stall_M: register ALU result, or a bubble if ~valid_E|flush_E.
//  - FSM BUSY: one multiplier bit per cycle; exactly XLEN cycles, then go DONE. ready_E=0.
//  - FSM DONE: ready_E=0. When ~stall_M: write product to EX/MEM (MUL: low XLEN bits, MULHU: high XLEN bits, unsigned); go IDLE.
//    - ready_E rises the cycle after the write.
//    - Total MUL latency: XLEN+2 cycles accept-to-valid_M with no stall.
//  - flush_E in BUSY/DONE: abort, go IDLE next cycle, no write; EX/MEM bubble if ~stall_M.
//  - stall_M=1: EX/MEM holds every field. BUSY still advances; DONE holds until release.
//  - Bubble = valid_M, RegWrite_M, MemWrite_M = 0; data fields don't-care (drive 0).
//  - Reset mid-multiply: immediate IDLE, partial product discarded.
//  - MUL_ENABLE=0: ready_E tied 1, FSM absent.
// STRUCTURE
//  - Package exec_pkg: ALU op localparams (ADD=0..SRA=9, MUL=10, MULHU=11), branch-op codes, forward-select codes, FSM state encoding.
//  - One sub-module: mul_iter (XLEN param; start/abort/done, 2*XLEN product).
//  - ALU, forwarding and branch compare stay inline.
// TESTING
//  1. Reset: rst=0 2 cycles with random inputs -> all *_M=0, ready_E=1.
//  2. ADD forwarding: RD1=5, ForwardA=10 (AluResult_M=7), Imm=3, ALUSrc=1 -> AluResult_M=10 next cycle.
//  3. BLT: SrcA=-1, SrcB=1, PC_E=0x100, Imm=0x20 -> PCSrc_E=1, PCTarget_E=0x120. BLTU, same operands -> PCSrc_E=0.
//  4. MUL/MULHU XLEN=32: 0xFFFFFFFF*2 -> MUL gives 0xFFFFFFFE and MULHU gives 1. ready_E low 33 cycles; valid_M at cycle 34.
//  5. stall_M held high 5 cycles across DONE -> product appears once on release; no duplicate valid_M.
//  6. flush_E at BUSY cycle 10 -> no valid_M from MUL; ready_E=1 next cycle; following ADD completes normally.

Source files
------------

// File: rtl/execute_stage_mc_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch ops, forwarding
// selects and multiplier FSM states.
package exec_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_MUL   = 4'd10;
  localparam logic [3:0] ALU_MULHU = 4'd11;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU);
  endfunction

endpackage

// File: rtl/execute_stage_mc_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// XLEN cycles per product. The product register holds after completion.
module mul_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              done,
  output logic [2*XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] mcand;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mplier;
  logic [CW-1:0]     count;
  logic              busy;

  // done is high during the cycle whose edge performs the last step
  assign done    = busy && (count == CW'(XLEN - 1));
  assign product = acc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      mcand  <= {{XLEN{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      count  <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolution,
// optional iterative multiplier, and the registered EX/MEM boundary.
module execute_stage_mc import exec_pkg::*; #(
  parameter int XLEN       = 32,
  parameter int MUL_ENABLE = 1,
  parameter int REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_E,
  output logic              ready_E,
  input  logic              flush_E,
  input  logic              stall_M,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   ImmExt_E,
  input  logic [XLEN-1:0]   PC_E,
  input  logic [XLEN-1:0]   PCPlus4_E,
  input  logic [REG_AW-1:0] Rd_E,
  input  logic [3:0]        ALUControl_E,
  input  logic              ALUSrc_E,
  input  logic [2:0]        BranchOp_E,
  input  logic              Branch_E,
  input  logic              Jump_E,
  input  logic              RegWrite_E,
  input  logic              MemWrite_E,
  input  logic [1:0]        ResultSrc_E,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic [XLEN-1:0]   ResultW,
  output logic              PCSrc_E,
  output logic [XLEN-1:0]   PCTarget_E,
  output logic              valid_M,
  output logic              RegWrite_M,
  output logic              MemWrite_M,
  output logic [1:0]        ResultSrc_M,
  output logic [REG_AW-1:0] Rd_M,
  output logic [XLEN-1:0]   AluResult_M,
  output logic [XLEN-1:0]   WriteData_M,
  output logic [XLEN-1:0]   PCPlus4_M
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0]   src_a, src_b, write_data, alu_result, mul_result;
  logic [SW-1:0]     shamt;
  logic              br_cond, mul_sel, mul_start, mul_abort;
  logic [1:0]        state;
  logic              lat_regwrite, lat_memwrite, lat_high;
  logic [1:0]        lat_resultsrc;
  logic [REG_AW-1:0] lat_rd;
  logic [XLEN-1:0]   lat_pc4;

  logic              load_m, nxt_valid, nxt_regwrite, nxt_memwrite;
  logic [1:0]        nxt_resultsrc;
  logic [REG_AW-1:0] nxt_rd;
  logic [XLEN-1:0]   nxt_alu, nxt_wd, nxt_pc4;

  // Encoding 11 falls through to the register-file value
  always_comb begin
    case (ForwardA_E)
      FWD_W:   src_a = ResultW;
      FWD_M:   src_a = AluResult_M;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      FWD_W:   write_data = ResultW;
      FWD_M:   write_data = AluResult_M;
      default: write_data = RD2_E;
    endcase
  end

  assign src_b = ALUSrc_E ? ImmExt_E : write_data;
  assign shamt = src_b[SW-1:0];

  always_comb begin
    case (ALUControl_E)
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(src_a) >>> shamt);
      default:  alu_result = src_a + src_b;
    endcase
  end

  always_comb begin
    case (BranchOp_E)
      BR_BEQ:  br_cond = (src_a == src_b);
      BR_BNE:  br_cond = (src_a != src_b);
      BR_BLT:  br_cond = ($signed(src_a) < $signed(src_b));
      BR_BGE:  br_cond = ($signed(src_a) >= $signed(src_b));
      BR_BLTU: br_cond = (src_a < src_b);
      BR_BGEU: br_cond = (src_a >= src_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign PCTarget_E = PC_E + ImmExt_E;
  assign PCSrc_E    = valid_E & ~flush_E & (state == ST_IDLE) &
                      (Jump_E | (Branch_E & br_cond));

  assign mul_sel   = (MUL_ENABLE != 0) && is_mul_op(ALUControl_E);
  assign mul_start = (state == ST_IDLE) & valid_E & ~flush_E & mul_sel;
  assign mul_abort = flush_E & (state != ST_IDLE);
  assign ready_E   = (state == ST_IDLE);

  generate
    if (MUL_ENABLE != 0) begin : g_mul
      logic [2*XLEN-1:0] product;
      logic              mul_done;

      mul_iter #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (mul_abort),
        .a       (src_a),
        .b       (src_b),
        .done    (mul_done),
        .product (product)
      );

      assign mul_result = lat_high ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];

      always_ff @(posedge clk) begin
        if (!rst) begin
          state         <= ST_IDLE;
          lat_regwrite  <= 1'b0;
          lat_memwrite  <= 1'b0;
          lat_high      <= 1'b0;
          lat_resultsrc <= '0;
          lat_rd        <= '0;
          lat_pc4       <= '0;
        end else begin
          case (state)
            ST_IDLE: if (mul_start) begin
              state         <= ST_BUSY;
              lat_regwrite  <= RegWrite_E;
              lat_memwrite  <= MemWrite_E;
              lat_high      <= (ALUControl_E == ALU_MULHU);
              lat_resultsrc <= ResultSrc_E;
              lat_rd        <= Rd_E;
              lat_pc4       <= PCPlus4_E;
            end
            ST_BUSY: if (flush_E) state <= ST_IDLE;
                     else if (mul_done) state <= ST_DONE;
            ST_DONE: if (flush_E || !stall_M) state <= ST_IDLE;
            default: state <= ST_IDLE;
          endcase
        end
      end
    end else begin : g_nomul
      assign state         = ST_IDLE;
      assign mul_result    = '0;
      assign lat_regwrite  = 1'b0;
      assign lat_memwrite  = 1'b0;
      assign lat_high      = 1'b0;
      assign lat_resultsrc = '0;
      assign lat_rd        = '0;
      assign lat_pc4       = '0;
    end
  endgenerate

  // Next EX/MEM contents; anything not explicitly loaded is a zeroed bubble
  always_comb begin
    load_m        = ~stall_M;
    nxt_valid     = 1'b0;
    nxt_regwrite  = 1'b0;
    nxt_memwrite  = 1'b0;
    nxt_resultsrc = '0;
    nxt_rd        = '0;
    nxt_alu       = '0;
    nxt_wd        = '0;
    nxt_pc4       = '0;
    if (state == ST_IDLE && valid_E && !flush_E && !mul_sel) begin
      nxt_valid     = 1'b1;
      nxt_regwrite  = RegWrite_E;
      nxt_memwrite  = MemWrite_E;
      nxt_resultsrc = ResultSrc_E;
      nxt_rd        = Rd_E;
      nxt_alu       = alu_result;
      nxt_wd        = write_data;
      nxt_pc4       = PCPlus4_E;
    end else if (state == ST_DONE && !flush_E) begin
      nxt_valid     = 1'b1;
      nxt_regwrite  = lat_regwrite;
      nxt_memwrite  = lat_memwrite;
      nxt_resultsrc = lat_resultsrc;
      nxt_rd        = lat_rd;
      nxt_alu       = mul_result;
      nxt_pc4       = lat_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_M     <= 1'b0;
      RegWrite_M  <= 1'b0;
      MemWrite_M  <= 1'b0;
      ResultSrc_M <= '0;
      Rd_M        <= '0;
      AluResult_M <= '0;
      WriteData_M <= '0;
      PCPlus4_M   <= '0;
    end else if (load_m) begin
      valid_M     <= nxt_valid;
      RegWrite_M  <= nxt_regwrite;
      MemWrite_M  <= nxt_memwrite;
      ResultSrc_M <= nxt_resultsrc;
      Rd_M        <= nxt_rd;
      AluResult_M <= nxt_alu;
      WriteData_M <= nxt_wd;
      PCPlus4_M   <= nxt_pc4;
    end
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc (XLEN=32): vector table for the
// single-cycle path plus sequences for multiply timing, stall, flush and reset.
module tb_execute_stage_mc;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_E, ready_E, flush_E, stall_M;
  logic [31:0] RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E, ResultW;
  logic [4:0]  Rd_E, Rd_M;
  logic [3:0]  ALUControl_E;
  logic        ALUSrc_E, Branch_E, Jump_E, RegWrite_E, MemWrite_E;
  logic [2:0]  BranchOp_E;
  logic [1:0]  ResultSrc_E, ForwardA_E, ForwardB_E, ResultSrc_M;
  logic        PCSrc_E, valid_M, RegWrite_M, MemWrite_M;
  logic [31:0] PCTarget_E, AluResult_M, WriteData_M, PCPlus4_M;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  execute_stage_mc #(.XLEN(32), .MUL_ENABLE(1), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .valid_E(valid_E), .ready_E(ready_E),
    .flush_E(flush_E), .stall_M(stall_M), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .ImmExt_E(ImmExt_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .Rd_E(Rd_E),
    .ALUControl_E(ALUControl_E), .ALUSrc_E(ALUSrc_E), .BranchOp_E(BranchOp_E),
    .Branch_E(Branch_E), .Jump_E(Jump_E), .RegWrite_E(RegWrite_E),
    .MemWrite_E(MemWrite_E), .ResultSrc_E(ResultSrc_E), .ForwardA_E(ForwardA_E),
    .ForwardB_E(ForwardB_E), .ResultW(ResultW), .PCSrc_E(PCSrc_E),
    .PCTarget_E(PCTarget_E), .valid_M(valid_M), .RegWrite_M(RegWrite_M),
    .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M), .Rd_M(Rd_M),
    .AluResult_M(AluResult_M), .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic        alusrc;
    logic [1:0]  fa, fb;
    logic [31:0] rw;
    logic [2:0]  bop;
    logic        br, jmp, fl;
    logic [31:0] pc;
    logic [31:0] e_alu, e_wd;
    logic        e_pcsrc;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic setIdle();
    valid_E = 0; flush_E = 0; stall_M = 0;
    RD1_E = 0; RD2_E = 0; ImmExt_E = 0; PC_E = 0; PCPlus4_E = 0; ResultW = 0;
    Rd_E = 0; ALUControl_E = ALU_ADD; ALUSrc_E = 0; BranchOp_E = 0;
    Branch_E = 0; Jump_E = 0; RegWrite_E = 0; MemWrite_E = 0; ResultSrc_E = 0;
    ForwardA_E = 0; ForwardB_E = 0;
  endtask

  task automatic applyStimulus(input int i);
    vec_t v;
    v = vecs[i];
    ALUControl_E = v.op; RD1_E = v.a; RD2_E = v.b; ImmExt_E = v.imm;
    ALUSrc_E = v.alusrc; ForwardA_E = v.fa; ForwardB_E = v.fb; ResultW = v.rw;
    BranchOp_E = v.bop; Branch_E = v.br; Jump_E = v.jmp; flush_E = v.fl;
    PC_E = v.pc; PCPlus4_E = v.pc + 32'd4; Rd_E = 5'(i);
    valid_E = 1; RegWrite_E = 1; MemWrite_E = 0; ResultSrc_E = 2'b01;
    #3;
    checkOutput($sformatf("v%0d_pcsrc", i), 64'(PCSrc_E), 64'(v.e_pcsrc));
    checkOutput($sformatf("v%0d_target", i), 64'(PCTarget_E), 64'(v.e_tgt));
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d_alu", i), 64'(AluResult_M), 64'(v.e_alu));
    checkOutput($sformatf("v%0d_wdata", i), 64'(WriteData_M), 64'(v.e_wd));
    checkOutput($sformatf("v%0d_valid", i), 64'(valid_M), 64'(!v.fl));
    checkOutput($sformatf("v%0d_rd", i), 64'(Rd_M), v.fl ? 64'd0 : 64'(i));
    checkOutput($sformatf("v%0d_regwrite", i), 64'(RegWrite_M), 64'(!v.fl));
    setIdle();
  endtask

  task automatic runMul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall_at, input int stall_len, input int flush_at,
                        output int low, output int first_ready, output int first_valid,
                        output int vcnt, output logic [31:0] res, output logic [4:0] res_rd);
    low = 0; first_ready = 0; first_valid = 0; vcnt = 0; res = 0; res_rd = 0;
    setIdle();
    ALUControl_E = op; RD1_E = a; RD2_E = b; valid_E = 1; RegWrite_E = 1;
    Rd_E = 5'd7; PCPlus4_E = 32'h44;
    #3;
    checkOutput("mul_ready_before_accept", 64'(ready_E), 64'd1);
    @(posedge clk); #1;
    valid_E = 0;
    for (int k = 1; k <= 60; k++) begin
      if (!ready_E) low++;
      else if (first_ready == 0) first_ready = k;
      if (valid_M) begin
        vcnt++;
        if (first_valid == 0) begin
          first_valid = k; res = AluResult_M; res_rd = Rd_M;
        end
      end
      stall_M = (k >= stall_at) && (k < stall_at + stall_len);
      flush_E = (k == flush_at);
      @(posedge clk); #1;
    end
    setIdle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int low, fr, fv, vc, cnt;
    logic [31:0] res;
    logic [4:0]  rrd;

    // Reset with random inputs on the pins
    rst = 0;
    setIdle();
    valid_E = 1'($urandom); flush_E = 1'($urandom); stall_M = 1'($urandom);
    RD1_E = $urandom; RD2_E = $urandom; ImmExt_E = $urandom; PC_E = $urandom;
    ALUControl_E = 4'($urandom_range(0, 11)); ForwardA_E = 2'($urandom);
    RegWrite_E = 1; MemWrite_E = 1; Rd_E = 5'($urandom); ResultSrc_E = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid_M", 64'(valid_M), 64'd0);
    checkOutput("rst_RegWrite_M", 64'(RegWrite_M), 64'd0);
    checkOutput("rst_MemWrite_M", 64'(MemWrite_M), 64'd0);
    checkOutput("rst_ResultSrc_M", 64'(ResultSrc_M), 64'd0);
    checkOutput("rst_Rd_M", 64'(Rd_M), 64'd0);
    checkOutput("rst_AluResult_M", 64'(AluResult_M), 64'd0);
    checkOutput("rst_WriteData_M", 64'(WriteData_M), 64'd0);
    checkOutput("rst_PCPlus4_M", 64'(PCPlus4_M), 64'd0);
    checkOutput("rst_ready_E", 64'(ready_E), 64'd1);
    setIdle();
    rst = 1;
    @(posedge clk); #1;

    //                op         a             b             imm         as    fa     fb     rw      bop      br    jmp   fl    pc            e_alu         e_wd          e_pc  e_tgt
    vecs.push_back(vec_t'{ALU_ADD,  32'd4,        32'd0,        32'd3,      1'b1, 2'b00, 2'b00, 32'd0, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'd7,        32'd0,        1'b0, 32'h3});
    vecs.push_back(vec_t'{ALU_ADD,  32'd5,        32'd0,        32'd3,      1'b1, 2'b10, 2'b00, 32'd0, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'd10,       32'd0,        1'b0, 32'h3});
    vecs.push_back(vec_t'{ALU_SUB,  32'd3,        32'd5,        32'd0,      1'b0, 2'b00, 2'b00, 32'd0, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFE, 32'd5,        1'b0, 32'h0});
    vecs.push_back(vec_t'{ALU_AND,  32'hF0F0,     32'hFF00,     32'd0,      1'b0, 2'b00, 2'b00, 32'd0, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'hF000,     32'hFF00,     1'b0, 32'h0});
    vecs.push_back(vec_t'{ALU_OR,   32'hF0F0,     32'h0F0F,     32'd0,      1'b0, 2'b00, 2'b00, 32'd0, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFF,     32'h0F0F,     1'b0, 32'h0});
    vecs.push_back(vec_t'{ALU_XOR,  32'hFF,       32'h0F,       32'd0,      1'b0, 2'b00, 2'b00, 32'd0, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'hF0,       32'h0F,       1'b0, 32'h0});
    vecs.push_back(vec_t'{ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd0,      1'b0, 2'b00, 2'b00, 32'd0, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'd1,        32'd1,        1'b0, 32'h0});
    vecs.push_back(vec_t'{ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,      1'b0, 2'b00, 2'b00, 32'd0, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'd0,        32'd1,        1'b0, 32'h0});
    vecs.push_back(vec_t'{ALU_SLL,  32'd1,        32'h3F,       32'd0,      1'b0, 2'b00, 2'b00, 32'd0, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'h80000000, 32'h3F,       1'b0, 32'h0});
    vecs.push_back(vec_t'{ALU_SRL,  32'h80000000, 32'd4,        32'd0,      1'b0, 2'b00, 2'b00, 32'd0, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'h08000000, 32'd4,        1'b0, 32'h0});
    vecs.push_back(vec_t'{ALU_SRA,  32'h80000000, 32'd4,        32'd0,      1'b0, 2'b00, 2'b00, 32'd0, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'hF8000000, 32'd4,        1'b0, 32'h0});
    vecs.push_back(vec_t'{ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,      1'b0, 2'b00, 2'b00, 32'd0, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'd0,        32'd1,        1'b0, 32'h0});
    vecs.push_back(vec_t'{ALU_ADD,  32'd1,        32'd100,      32'd0,      1'b0, 2'b00, 2'b01, 32'd9, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'd10,       32'd9,        1'b0, 32'h0});
    vecs.push_back(vec_t'{ALU_ADD,  32'd2,        32'd0,        32'd3,      1'b1, 2'b11, 2'b00, 32'd9, 3'd0,    1'b0, 1'b0, 1'b0, 32'h0,        32'd5,        32'd0,        1'b0, 32'h3});
    vecs.push_back(vec_t'{ALU_SUB,  32'hFFFFFFFF, 32'd1,        32'h20,     1'b0, 2'b00, 2'b00, 32'd0, BR_BLT,  1'b1, 1'b0, 1'b0, 32'h100,      32'hFFFFFFFE, 32'd1,        1'b1, 32'h120});
    vecs.push_back(vec_t'{ALU_SUB,  32'hFFFFFFFF, 32'd1,        32'h20,     1'b0, 2'b00, 2'b00, 32'd0, BR_BLTU, 1'b1, 1'b0, 1'b0, 32'h100,      32'hFFFFFFFE, 32'd1,        1'b0, 32'h120});
    vecs.push_back(vec_t'{ALU_SUB,  32'd5,        32'd5,        32'h8,      1'b0, 2'b00, 2'b00, 32'd0, BR_BEQ,  1'b1, 1'b0, 1'b0, 32'h0,        32'd0,        32'd5,        1'b1, 32'h8});
    vecs.push_back(vec_t'{ALU_SUB,  32'd5,        32'd5,        32'h8,      1'b0, 2'b00, 2'b00, 32'd0, BR_BNE,  1'b1, 1'b0, 1'b0, 32'h0,        32'd0,        32'd5,        1'b0, 32'h8});
    vecs.push_back(vec_t'{ALU_SUB,  32'hFFFFFFFF, 32'd1,        32'h8,      1'b0, 2'b00, 2'b00, 32'd0, BR_BGE,  1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFE, 32'd1,        1'b0, 32'h8});
    vecs.push_back(vec_t'{ALU_SUB,  32'hFFFFFFFF, 32'd1,        32'h8,      1'b0, 2'b00, 2'b00, 32'd0, BR_BGEU, 1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFE, 32'd1,        1'b1, 32'h8});
    vecs.push_back(vec_t'{ALU_ADD,  32'd0,        32'd0,        32'h10,     1'b1, 2'b00, 2'b00, 32'd0, 3'd0,    1'b0, 1'b1, 1'b0, 32'h200,      32'h10,       32'd0,        1'b1, 32'h210});
    vecs.push_back(vec_t'{ALU_ADD,  32'd0,        32'd0,        32'h10,     1'b1, 2'b00, 2'b00, 32'd0, 3'd0,    1'b0, 1'b1, 1'b1, 32'h200,      32'd0,        32'd0,        1'b0, 32'h210});

    for (int i = 0; i < vecs.size(); i++) applyStimulus(i);

    // MUL: 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    runMul(ALU_MUL, 32'hFFFFFFFF, 32'd2, 0, 0, 0, low, fr, fv, vc, res, rrd);
    checkOutput("mul_result", 64'(res), 64'hFFFFFFFE);
    checkOutput("mul_rd", 64'(rrd), 64'd7);
    checkOutput("mul_ready_low_cycles", 64'(low), 64'd33);
    checkOutput("mul_valid_cycle", 64'(fv), 64'd34);
    checkOutput("mul_ready_rise_cycle", 64'(fr), 64'd34);
    checkOutput("mul_valid_count", 64'(vc), 64'd1);

    runMul(ALU_MULHU, 32'hFFFFFFFF, 32'd2, 0, 0, 0, low, fr, fv, vc, res, rrd);
    checkOutput("mulhu_result", 64'(res), 64'd1);
    checkOutput("mulhu_valid_cycle", 64'(fv), 64'd34);

    runMul(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, low, fr, fv, vc, res, rrd);
    checkOutput("mulhu_max_result", 64'(res), 64'hFFFFFFFE);

    runMul(ALU_MUL, 32'h12345678, 32'h10, 0, 0, 0, low, fr, fv, vc, res, rrd);
    checkOutput("mul_shift_result", 64'(res), 64'h23456780);

    // stall_M for 5 edges while the product waits in DONE
    runMul(ALU_MUL, 32'hFFFFFFFF, 32'd2, 33, 5, 0, low, fr, fv, vc, res, rrd);
    checkOutput("stall_result", 64'(res), 64'hFFFFFFFE);
    checkOutput("stall_valid_cycle", 64'(fv), 64'd39);
    checkOutput("stall_valid_count", 64'(vc), 64'd1);
    checkOutput("stall_ready_low_cycles", 64'(low), 64'd38);

    // flush at BUSY cycle 10
    runMul(ALU_MUL, 32'hFFFFFFFF, 32'd2, 0, 0, 10, low, fr, fv, vc, res, rrd);
    checkOutput("flush_valid_count", 64'(vc), 64'd0);
    checkOutput("flush_ready_rise_cycle", 64'(fr), 64'd11);
    checkOutput("flush_ready_low_cycles", 64'(low), 64'd10);
    applyStimulus(0);

    // Reset in the middle of a multiply discards it
    setIdle();
    ALUControl_E = ALU_MUL; RD1_E = 32'd3; RD2_E = 32'd5; valid_E = 1; RegWrite_E = 1;
    @(posedge clk); #1;
    setIdle();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midrst_busy_ready", 64'(ready_E), 64'd0);
    rst = 0;
    @(posedge clk); #1;
    checkOutput("midrst_ready_E", 64'(ready_E), 64'd1);
    rst = 1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (valid_M) cnt++;
    end
    checkOutput("midrst_no_late_product", 64'(cnt), 64'd0);
    applyStimulus(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
